display_scan_master: RTL
========================

// Module: display_scan_master
// PURPOSE
//  Initiator side of the display_number/display_valid/display_name/display_value
//  block protocol. Sweeps block numbers 1..NUM_BLOCKS, waits for the registered
//  responder (a *_display module), captures each valid block and streams it out
//  on a valid/ready port toward the LCD text renderer. Sweeps repeat every refresh period.
// PARAMETERS
//  NUM_BLOCKS    44   highest block number issued (1..63)
//  RESP_LAT      2    cycles display_number is held before sampling (>=1)
//  REFRESH_GAP   1024 idle cycles between end of one sweep and start of next
// PORTS
//  clk            in   1   system clock
//  resetn         in   1   synchronous active-low reset
//  enable         in   1   1 = run sweeps; 0 = stop after current block
//  display_number out  6   block number presented to responder
//  display_valid  in   1   responder: block is populated
//  display_name   in   40  responder: 5 ASCII chars, [39:32] = first char
//  display_value  in   32  responder: block value
//  out_valid      out  1   captured entry available
//  out_ready      in   1   downstream accepts entry
//  out_number     out  6   block number of entry
//  out_name       out  40  captured name
//  out_value      out  32  captured value
//  sweep_done     out  1   one-cycle pulse after last block of a sweep handled
//  busy           out  1   1 whenever state != IDLE
// BEHAVIOUR
//  Reset (clk edge with resetn=0): state IDLE, display_number=0, out_valid=0,
//   out_number/name/value=0, sweep_done=0, gap counter=0, block counter=1.
//  Block 0 is never issued; display_number=0 in IDLE/GAP (responder returns invalid).
//  FSM: IDLE -> ISSUE when enable=1.
//   ISSUE: drive display_number=blk; clear wait counter; -> WAIT.
//   WAIT: hold display_number; after RESP_LAT cycles in WAIT sample inputs on
//    that edge; -> EMIT if display_valid=1 (and emit-filter passes), else -> NEXT.
//   EMIT: out_valid=1, out_* stable; transfer on clk edge with out_valid&out_ready;
//    -> NEXT. Fields never change while out_valid=1 and out_ready=0.
//   NEXT: if blk==NUM_BLOCKS: blk<=1, sweep_done pulse, -> GAP (enable=1) or
//    IDLE (enable=0); else blk<=blk+1, -> ISSUE (enable=1) or IDLE (enable=0).
//   GAP: count REFRESH_GAP cycles -> ISSUE; enable=0 during GAP -> IDLE.
//  Minimum per-block cost: 1 (ISSUE) + RESP_LAT + 1 (NEXT) cycles, +1 min for EMIT.
//  enable dropping mid-block: current block completes (including EMIT handshake);
//   blk advances as normal; re-enable resumes at stored blk (not 1).
//  Reset mid-EMIT: entry dropped, out_valid=0 next cycle, no partial transfer.
//  display_valid sampled only at the defined edge; changes elsewhere ignored.
//  out_ready high while out_valid=0 has no effect.
// CONFIGURATION
//  `define DISP_CHANGE_ONLY_EN:
//   with it: per-block shadow {seen,value} (NUM_BLOCKS x 33 bits); a valid block
//    is emitted only if seen=0 or value != shadow; shadow updated on transfer.
//    Reset clears all seen bits, so first sweep emits every valid block.
//    Name changes alone do not trigger emission.
//   without it: every valid block is emitted every sweep; no shadow storage.
// TESTING
//  T1 reset, enable=1, responder valid only on blocks 1..6, out_ready=1 -> exactly
//   6 entries, out_number 1..6 in order, one sweep_done after block 44.
//  T2 block 5 name "WADDR" value 32'h3, out_ready=0 for 20 cycles -> out_valid
//   held, out_value=3, display_number stays 5, no further blocks issued.
//  T3 enable=0 during WAIT of block 10 -> block 10 finishes, busy=0, display_number=0;
//   re-enable -> first issued block is 11.
//  T4 REFRESH_GAP=16: sweep_done to next display_number=1 spans exactly 16 GAP
//   cycles + 1 ISSUE cycle.
//  T5 resetn=0 while out_valid=1 -> next cycle out_valid=0, display_number=0,
//   next sweep starts at block 1.
//  T6 (DISP_CHANGE_ONLY_EN) 2 sweeps, only block 7 value 0->32'hDEAD between them
//   -> sweep 2 emits only block 7; without macro sweep 2 emits all valid blocks.

Source files
------------

// File: rtl/display_scan_master.sv
// Initiator for the display_number/valid/name/value block protocol: sweeps blocks 1..NUM_BLOCKS,
// captures valid blocks and streams them out. Optional: `define DISP_CHANGE_ONLY_EN.
module display_scan_master #(
    parameter int unsigned NUM_BLOCKS  = 44,
    parameter int unsigned RESP_LAT    = 2,
    parameter int unsigned REFRESH_GAP = 1024
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        enable,
    output logic [5:0]  display_number,
    input  logic        display_valid,
    input  logic [39:0] display_name,
    input  logic [31:0] display_value,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [5:0]  out_number,
    output logic [39:0] out_name,
    output logic [31:0] out_value,
    output logic        sweep_done,
    output logic        busy
);

    localparam int unsigned WaitW = (RESP_LAT > 1) ? $clog2(RESP_LAT) : 1;
    localparam int unsigned GapW  = (REFRESH_GAP > 1) ? $clog2(REFRESH_GAP) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StEmit,
        StNext,
        StGap
    } state_e;

    state_e            state_q, state_d;
    logic [5:0]        blk_q;
    logic [WaitW-1:0]  wait_cnt_q;
    logic [GapW-1:0]   gap_cnt_q;

    logic sample_now;
    logic transfer;
    logic last_blk;
    logic gap_done;
    logic emit_ok;

    assign sample_now = (state_q == StWait) && (wait_cnt_q == WaitW'(RESP_LAT - 1));
    assign transfer   = (state_q == StEmit) && out_valid && out_ready;
    assign last_blk   = (blk_q == 6'(NUM_BLOCKS));
    assign gap_done   = (gap_cnt_q == GapW'(REFRESH_GAP - 1));
    assign busy       = (state_q != StIdle);

`ifdef DISP_CHANGE_ONLY_EN
    localparam int unsigned IdxW = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;

    logic [NUM_BLOCKS-1:0] seen_q;
    logic [31:0]           shadow_q [NUM_BLOCKS];
    logic [IdxW-1:0]       blk_idx;
    logic [IdxW-1:0]       out_idx;

    assign blk_idx = IdxW'(blk_q - 6'd1);
    assign out_idx = IdxW'(out_number - 6'd1);
    // Name changes alone are deliberately ignored; only the value is tracked.
    assign emit_ok = !seen_q[blk_idx] || (display_value != shadow_q[blk_idx]);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            seen_q <= '0;
        end else if (transfer) begin
            seen_q[out_idx] <= 1'b1;
        end
    end

    // Shadow values need no reset: they are only consulted once the seen bit is set.
    always_ff @(posedge clk) begin
        if (transfer) begin
            shadow_q[out_idx] <= out_value;
        end
    end
`else
    assign emit_ok = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (enable) state_d = StIssue;
            end
            StIssue: begin
                state_d = StWait;
            end
            StWait: begin
                if (sample_now) begin
                    state_d = (display_valid && emit_ok) ? StEmit : StNext;
                end
            end
            StEmit: begin
                if (out_ready) state_d = StNext;
            end
            StNext: begin
                if (!enable) begin
                    state_d = StIdle;
                end else if (last_blk) begin
                    state_d = StGap;
                end else begin
                    state_d = StIssue;
                end
            end
            StGap: begin
                if (!enable) begin
                    state_d = StIdle;
                end else if (gap_done) begin
                    state_d = StIssue;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q        <= StIdle;
            blk_q          <= 6'd1;
            wait_cnt_q     <= '0;
            gap_cnt_q      <= '0;
            display_number <= '0;
            out_valid      <= 1'b0;
            out_number     <= '0;
            out_name       <= '0;
            out_value      <= '0;
            sweep_done     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sweep_done <= 1'b0;
            unique case (state_q)
                StIssue: begin
                    display_number <= blk_q;
                    wait_cnt_q     <= '0;
                end
                StWait: begin
                    if (!sample_now) begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end else if (display_valid && emit_ok) begin
                        out_valid  <= 1'b1;
                        out_number <= blk_q;
                        out_name   <= display_name;
                        out_value  <= display_value;
                    end
                end
                StEmit: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                StNext: begin
                    gap_cnt_q <= '0;
                    if (last_blk) begin
                        blk_q      <= 6'd1;
                        sweep_done <= 1'b1;
                    end else begin
                        blk_q <= blk_q + 6'd1;
                    end
                    // Block 0 is the responder's "nothing selected" code.
                    if (last_blk || !enable) display_number <= '0;
                end
                StGap: begin
                    gap_cnt_q <= gap_done ? '0 : gap_cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
